// File: rtl/idct_block_ram.sv
// 64x16 coefficient store and run controller for one Fast_IDCT core.
// The core sees a byte-addressed memory; the host gets a word-indexed load/unload port.
module idct_block_ram #(
  parameter int BASE_ADDR    = 0,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  output logic        busy,
  output logic        block_done,
  output logic        timeout,
  output logic        addr_err,
  input  logic        err_clr,
  output logic [31:0] cycle_count,
  input  logic        host_en,
  input  logic        host_we,
  input  logic [5:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        idct_start,
  input  logic        idct_done,
  input  logic        Mout_oe_ram,
  input  logic        Mout_we_ram,
  input  logic [31:0] Mout_addr_ram,
  input  logic [15:0] Mout_Wdata_ram,
  input  logic [4:0]  Mout_data_ram_size,
  output logic [15:0] M_Rdata_ram,
  output logic        M_DataRdy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_mem [64];
  logic [15:0] r_hrdata;
  logic [15:0] r_rdata;
  logic        r_rsp;
  logic [31:0] r_cnt;
  logic [31:0] r_cycles;
  logic        r_block_done;
  logic        r_timeout;
  logic        r_addr_err;

  logic [31:0] w_off;
  logic        w_in_range;
  logic [5:0]  w_idx;
  logic [15:0] w_mask;
  logic        w_req;
  logic        w_accept;
  logic        w_bad;
  logic        w_core_wr;
  logic [15:0] w_rd_data;
  logic        w_host_ok;
  logic        w_mem_we;
  logic [5:0]  w_mem_addr;
  logic [15:0] w_mem_data;
  logic        w_timeout_hit;

  // Size 0 and anything wider than the word both mean a full 16-bit access.
  function automatic logic [15:0] size_mask(input logic [4:0] s);
    logic [16:0] m;
    if (s == 5'd0 || s > 5'd16) begin
      m = 17'h0FFFF;
    end else begin
      m = (17'd1 << s) - 17'd1;
    end
    return m[15:0];
  endfunction

  always_comb begin
    w_off      = Mout_addr_ram - 32'(BASE_ADDR);
    w_in_range = (w_off < 32'd128);
    w_idx      = w_off[6:1];
    w_mask     = size_mask(Mout_data_ram_size);
    w_req      = Mout_oe_ram | Mout_we_ram;
    // With a registered response, the cycle after acceptance is the reply slot and is not re-serviced.
    w_accept   = (READ_LATENCY == 0) ? w_req : (w_req & ~r_rsp);
    w_bad      = w_req & (~w_in_range | (Mout_oe_ram & Mout_we_ram));
    w_core_wr  = w_accept & Mout_we_ram & ~Mout_oe_ram & w_in_range;
    w_rd_data  = (w_accept & Mout_oe_ram & ~Mout_we_ram & w_in_range) ?
                 (r_mem[w_idx] & w_mask) : 16'h0000;
    w_host_ok  = host_en & (r_state == S_IDLE);
    w_mem_we   = w_core_wr | (w_host_ok & host_we);
    w_mem_addr = w_core_wr ? w_idx : host_addr;
    w_mem_data = w_core_wr ? (Mout_Wdata_ram & w_mask) : host_wdata;
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hrdata   <= 16'h0000;
      r_rsp      <= 1'b0;
      r_rdata    <= 16'h0000;
      r_addr_err <= 1'b0;
    end else begin
      if (w_host_ok && !host_we) begin
        r_hrdata <= r_mem[host_addr];
      end
      r_rsp <= (READ_LATENCY != 0) && w_accept;
      if (w_accept) begin
        r_rdata <= w_rd_data;
      end
      if (w_accept && w_bad) begin
        r_addr_err <= 1'b1;
      end else if (err_clr) begin
        r_addr_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE:  if (go) w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN: begin
        if (idct_done) begin
          w_next = S_IDLE;
        end else if (r_cnt == 32'(TIMEOUT)) begin
          w_timeout_hit = 1'b1;
          w_next        = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_cnt holds the number of cycles already elapsed since the start cycle, counting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= 32'd0;
      r_cycles     <= 32'd0;
      r_block_done <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_block_done <= (r_state == S_RUN) && idct_done;
      if (r_state == S_START) begin
        r_cnt <= 32'd1;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == S_RUN && idct_done) begin
        r_cycles <= r_cnt + 32'd1;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end else if (err_clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign idct_start  = (r_state == S_START);
  assign block_done  = r_block_done;
  assign timeout     = r_timeout;
  assign addr_err    = r_addr_err;
  assign cycle_count = r_cycles;
  assign host_rdata  = r_hrdata;
  assign M_DataRdy   = (READ_LATENCY == 0) ? w_req : r_rsp;
  assign M_Rdata_ram = (READ_LATENCY == 0) ? w_rd_data : r_rdata;

endmodule

// File: tb/tb_idct_block_ram.sv
// Directed bench: dut1 uses a registered core port, dut2 a combinational one with a short watchdog.
module tb_idct_block_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        go, go2, err_clr, done, done2;
  logic        host_en, host_we;
  logic [5:0]  host_addr;
  logic [15:0] host_wdata;
  logic        oe, we;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [4:0]  size;

  logic        busy, bdone, tmo, aerr, start, rdy;
  logic [31:0] ccnt;
  logic [15:0] hrd, rdata;
  logic        busy2, bdone2, tmo2, aerr2, start2, rdy2;
  logic [31:0] ccnt2;
  logic [15:0] hrd2, rdata2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  idct_block_ram #(.BASE_ADDR(0), .READ_LATENCY(1), .TIMEOUT(4096)) dut1 (
    .clock(clk), .reset(rst), .go(go), .busy(busy), .block_done(bdone),
    .timeout(tmo), .addr_err(aerr), .err_clr(err_clr), .cycle_count(ccnt),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(hrd), .idct_start(start),
    .idct_done(done), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata),
    .M_DataRdy(rdy));

  idct_block_ram #(.BASE_ADDR(0), .READ_LATENCY(0), .TIMEOUT(16)) dut2 (
    .clock(clk), .reset(rst), .go(go2), .busy(busy2), .block_done(bdone2),
    .timeout(tmo2), .addr_err(aerr2), .err_clr(err_clr), .cycle_count(ccnt2),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(hrd2), .idct_start(start2),
    .idct_done(done2), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata2),
    .M_DataRdy(rdy2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_set(input logic o, input logic w, input logic [31:0] a,
                          input logic [4:0] s, input logic [15:0] d);
    oe = o; we = w; addr = a; size = s; wdata = d;
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [15:0] d);
    host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_en = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [5:0] a);
    host_en = 1'b1; host_we = 1'b0; host_addr = a;
    tick();
    host_en = 1'b0;
  endtask

  // Registered-port read: request one cycle, expect response the next.
  task automatic core_rd(input string tag, input logic [31:0] a, input logic [4:0] s,
                         input logic [15:0] exp);
    core_set(1'b1, 1'b0, a, s, 16'h0);
    tick();
    check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    check({tag, "_data"}, {16'd0, rdata}, {16'd0, exp});
    core_set(1'b0, 1'b0, 32'd0, 5'd0, 16'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [15:0] v;
    int          seen;
    rst = 1'b1; go = 1'b0; go2 = 1'b0; err_clr = 1'b0; done = 1'b0; done2 = 1'b0;
    host_en = 1'b0; host_we = 1'b0; host_addr = 6'd0; host_wdata = 16'h0;
    core_set(1'b0, 1'b0, 32'd0, 5'd0, 16'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_block_done", {31'd0, bdone}, 32'd0);
    check("rst_timeout", {31'd0, tmo}, 32'd0);
    check("rst_addr_err", {31'd0, aerr}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_rdy", {31'd0, rdy}, 32'd0);
    check("rst_cycle_count", ccnt, 32'd0);
    check("rst_host_rdata", {16'd0, hrd}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);

    for (int i = 0; i < 64; i++) begin
      if (i == 0)       v = 16'hFF10;
      else if (i == 1)  v = 16'h0008;
      else if (i == 63) v = 16'hFFF8;
      else              v = 16'(16'h0100 + i * 3);
      host_wr(6'(i), v);
    end
    host_rd(6'd1);
    check("host_rd_w1", {16'd0, hrd}, 32'h0008);

    core_rd("rd_a0", 32'd0, 5'd16, 16'hFF10);
    core_rd("rd_a126", 32'd126, 5'd16, 16'hFFF8);

    // Held request: serviced once, reply slot skipped, serviced again.
    core_set(1'b1, 1'b0, 32'd2, 5'd16, 16'h0);
    #1;
    check("rl0_rdy", {31'd0, rdy2}, 32'd1);
    check("rl0_data", {16'd0, rdata2}, 32'h0008);
    tick();
    check("hold_rdy_t1", {31'd0, rdy}, 32'd1);
    check("hold_data_t1", {16'd0, rdata}, 32'h0008);
    tick();
    check("hold_rdy_t2", {31'd0, rdy}, 32'd0);
    tick();
    check("hold_rdy_t3", {31'd0, rdy}, 32'd1);
    core_set(1'b0, 1'b0, 32'd0, 5'd0, 16'h0);
    tick();

    core_set(1'b0, 1'b1, 32'd4, 5'd8, 16'h1234);
    tick();
    check("wr8_rdy", {31'd0, rdy}, 32'd1);
    core_set(1'b0, 1'b0, 32'd0, 5'd0, 16'h0);
    tick();
    host_rd(6'd2);
    check("host_rd_w2_masked", {16'd0, hrd}, 32'h0034);
    core_rd("rd_size4", 32'd4, 5'd4, 16'h0004);
    core_rd("rd_size0", 32'd4, 5'd0, 16'h0034);

    host_en = 1'b1; host_we = 1'b1; host_addr = 6'd5; host_wdata = 16'hABCD;
    tick();
    host_en = 1'b0; host_we = 1'b0;
    core_rd("host_then_core", 32'd10, 5'd16, 16'hABCD);

    check("no_err_yet", {31'd0, aerr}, 32'd0);
    core_set(1'b1, 1'b0, 32'd128, 5'd16, 16'h0);
    tick();
    check("oor_rdy", {31'd0, rdy}, 32'd1);
    check("oor_data", {16'd0, rdata}, 32'd0);
    check("oor_addr_err", {31'd0, aerr}, 32'd1);
    core_set(1'b0, 1'b0, 32'd0, 5'd0, 16'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", {31'd0, aerr}, 32'd0);
    core_set(1'b1, 1'b1, 32'd6, 5'd16, 16'hFFFF);
    tick();
    check("oe_we_addr_err", {31'd0, aerr}, 32'd1);
    check("oe_we_data", {16'd0, rdata}, 32'd0);
    core_set(1'b0, 1'b0, 32'd0, 5'd0, 16'h0);
    tick();
    core_rd("oe_we_unchanged", 32'd6, 5'd16, 16'h0109);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Block run: done 37 cycles after the start cycle.
    go = 1'b1;
    tick();
    go = 1'b0;
    check("start_pulse", {31'd0, start}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 37; k++) begin
      if (k == 5) go = 1'b1;
      if (k == 6) host_wr(6'd8, 16'hDEAD);
      else tick();
      go = 1'b0;
      if (k == 1) check("start_one_cycle", {31'd0, start}, 32'd1 ^ 32'd1);
      if (k == 6) check("go_in_run_ignored", {31'd0, start}, 32'd0);
      if (k == 20) check("run_busy", {31'd0, busy}, 32'd1);
    end
    done = 1'b1;
    check("bdone_not_early", {31'd0, bdone}, 32'd0);
    tick();
    done = 1'b0;
    check("bdone_pulse", {31'd0, bdone}, 32'd1);
    check("cycle_count", ccnt, 32'd38);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    tick();
    check("bdone_one_cycle", {31'd0, bdone}, 32'd0);
    host_rd(6'd8);
    check("host_wr_in_run_ignored", {16'd0, hrd}, 32'h0118);

    // Watchdog on dut2.
    go2 = 1'b1;
    tick();
    go2 = 1'b0;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bdone2) seen++;
    end
    check("tmo_still_run", {31'd0, busy2}, 32'd1);
    check("tmo_not_yet", {31'd0, tmo2}, 32'd0);
    tick();
    if (bdone2) seen++;
    check("tmo_set", {31'd0, tmo2}, 32'd1);
    check("tmo_idle", {31'd0, busy2}, 32'd0);
    tick();
    if (bdone2) seen++;
    check("tmo_no_block_done", 32'(seen), 32'd0);
    host_wr(6'd7, 16'h5555);
    host_rd(6'd7);
    check("host_after_tmo", {16'd0, hrd2}, 32'h5555);

    // Reset in the middle of a run.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_start", {31'd0, start}, 32'd0);
    check("midrun_rst_bdone", {31'd0, bdone}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
